// File: rtl/rewrite_seq_ctrl.sv
// rewrite_seq_ctrl: pairs each rewrite descriptor with its packet byte stream,
// strobes start-of-packet to the rewrite mux and enforces the expected length.
module rewrite_seq_ctrl #(
   parameter int ACTION_W = 64
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                desc_valid,
   output logic                desc_ready,
   input  logic [ACTION_W-1:0] desc_action,
   input  logic [15:0]         desc_l2_off,
   input  logic [15:0]         desc_l3_off,
   input  logic [15:0]         desc_l4_off,
   input  logic [15:0]         desc_len,
   input  logic                s_valid,
   input  logic [7:0]          s_data,
   input  logic                s_last,
   output logic                s_ready,
   output logic                m_valid,
   output logic [7:0]          m_data,
   output logic                m_last,
   input  logic                m_ready,
   output logic                pkt_sop,
   output logic [ACTION_W-1:0] action,
   output logic [15:0]         l2_offset,
   output logic [15:0]         l3_offset,
   output logic [15:0]         l4_offset,
   output logic                busy,
   output logic [31:0]         pkt_count,
   output logic [15:0]         len_err_count
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SOP    = 2'd1,
      STREAM = 2'd2,
      DRAIN  = 2'd3
   } state_t;

   state_t      state;
   state_t      next_state;
   logic [15:0] byte_count;
   logic [15:0] exp_len;
   logic        desc_fire;
   logic        s_fire;
   logic        len_set;
   logic        len_hit;

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign desc_fire = desc_valid && desc_ready;
   assign s_fire    = s_valid && s_ready;
   assign len_set   = (exp_len != 16'd0);
   // The byte being accepted now is the last one the descriptor allows.
   assign len_hit   = len_set && ((byte_count + 16'd1) == exp_len);
   assign busy      = (state != IDLE);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (desc_fire) next_state = SOP;
            else           next_state = IDLE;
         end
         SOP: next_state = STREAM;
         STREAM: begin
            if (s_fire && s_last)       next_state = IDLE;
            else if (s_fire && len_hit) next_state = DRAIN;
            else                        next_state = STREAM;
         end
         DRAIN: begin
            if (s_fire && s_last) next_state = IDLE;
            else                  next_state = DRAIN;
         end
         default: next_state = IDLE;
      endcase
   end

   // Output decode; STREAM is a combinational pass-through to the mux
   always_comb begin
      desc_ready = 1'b0;
      s_ready    = 1'b0;
      m_valid    = 1'b0;
      m_data     = 8'h00;
      m_last     = 1'b0;
      pkt_sop    = 1'b0;
      case (state)
         IDLE:   desc_ready = !rst;
         SOP:    pkt_sop = 1'b1;
         STREAM: begin
            m_valid = s_valid;
            m_data  = s_data;
            m_last  = s_last || len_hit;
            s_ready = m_ready;
         end
         DRAIN:   s_ready = 1'b1;
         default: desc_ready = 1'b0;
      endcase
   end

   // Descriptor fields held from acceptance until the next descriptor
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         action    <= {ACTION_W{1'b0}};
         l2_offset <= 16'd0;
         l3_offset <= 16'd0;
         l4_offset <= 16'd0;
         exp_len   <= 16'd0;
      end else if (desc_fire) begin
         action    <= desc_action;
         l2_offset <= desc_l2_off;
         l3_offset <= desc_l3_off;
         l4_offset <= desc_l4_off;
         exp_len   <= desc_len;
      end
   end

   // Byte counter plus saturating packet and length-error statistics
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         byte_count    <= 16'd0;
         pkt_count     <= 32'd0;
         len_err_count <= 16'd0;
      end else if (desc_fire) begin
         byte_count <= 16'd0;
      end else if ((state == STREAM) && s_fire) begin
         byte_count <= byte_count + 16'd1;
         if (s_last) begin
            pkt_count <= sat_inc32(pkt_count);
            if (len_set && !len_hit) begin
               len_err_count <= sat_inc16(len_err_count);
            end
         end else if (len_hit) begin
            pkt_count     <= sat_inc32(pkt_count);
            len_err_count <= sat_inc16(len_err_count);
         end
      end
   end

endmodule

// File: tb/tb_rewrite_seq_ctrl.sv
// Directed, table-driven bench for rewrite_seq_ctrl with hand-written sequences
// for back-to-back descriptors and mid-packet reset.
module tb_rewrite_seq_ctrl;

   logic        clk;
   logic        rst;
   logic        desc_valid;
   logic        desc_ready;
   logic [63:0] desc_action;
   logic [15:0] desc_l2_off, desc_l3_off, desc_l4_off, desc_len;
   logic        s_valid, s_last, s_ready;
   logic [7:0]  s_data;
   logic        m_valid, m_last, m_ready;
   logic [7:0]  m_data;
   logic        pkt_sop;
   logic [63:0] action;
   logic [15:0] l2_offset, l3_offset, l4_offset;
   logic        busy;
   logic [31:0] pkt_count;
   logic [15:0] len_err_count;

   rewrite_seq_ctrl #(.ACTION_W(64)) dut (
      .clk(clk), .rst(rst),
      .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_action(desc_action),
      .desc_l2_off(desc_l2_off), .desc_l3_off(desc_l3_off), .desc_l4_off(desc_l4_off),
      .desc_len(desc_len),
      .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
      .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
      .pkt_sop(pkt_sop), .action(action),
      .l2_offset(l2_offset), .l3_offset(l3_offset), .l4_offset(l4_offset),
      .busy(busy), .pkt_count(pkt_count), .len_err_count(len_err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   typedef struct {
      logic [15:0] len;
      int          nbytes;
      logic [63:0] act;
      bit          toggle;
      int          exp_out;
      int          exp_err;
      int          exp_bc;
   } vec_t;

   vec_t        vecs[6];
   int          checks;
   int          failures;
   logic [63:0] cur_action;
   logic [15:0] cur_l2, cur_l3, cur_l4;
   int          exp_pkt;
   int          exp_err;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%b expected=%b at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] byte_of(input int p, input int i);
      return 8'(p * 16 + i * 7 + 3);
   endfunction

   task automatic send_desc(input int p, input logic [63:0] act, input logic [15:0] len,
                            input logic [15:0] l2, input logic [15:0] l3, input logic [15:0] l4);
      @(negedge clk);
      desc_valid  = 1'b1;
      desc_action = act;
      desc_len    = len;
      desc_l2_off = l2;
      desc_l3_off = l3;
      desc_l4_off = l4;
      s_valid     = 1'b1;
      s_data      = byte_of(p, 0);
      s_last      = 1'b0;
      #1;
      chk1("idle_desc_ready", desc_ready, 1'b1);
      chk1("idle_s_ready", s_ready, 1'b0);
      chk1("idle_m_valid", m_valid, 1'b0);
      chk("idle_action_held", action, cur_action);
      @(posedge clk);
      @(negedge clk);
      desc_valid = 1'b0;
      cur_action = act;
      cur_l2 = l2;
      cur_l3 = l3;
      cur_l4 = l4;
      #1;
      chk1("sop_strobe", pkt_sop, 1'b1);
      chk1("sop_m_valid", m_valid, 1'b0);
      chk1("sop_s_ready", s_ready, 1'b0);
      chk1("sop_desc_ready", desc_ready, 1'b0);
      chk1("sop_busy", busy, 1'b1);
      chk("sop_action", action, act);
      chk("sop_l2", 64'(l2_offset), 64'(l2));
      chk("sop_l3", 64'(l3_offset), 64'(l3));
      chk("sop_l4", 64'(l4_offset), 64'(l4));
   endtask

   task automatic stream_pkt(input int p, input int nbytes, input int exp_out, input bit toggle,
                             input int stop_after, input bit hold_next, input logic [63:0] next_act,
                             output int nout);
      int bi;
      int cyc;
      bi = 0;
      cyc = 0;
      nout = 0;
      while (bi < stop_after && cyc < 200) begin
         @(negedge clk);
         s_valid     = 1'b1;
         s_data      = byte_of(p, bi);
         s_last      = (bi == nbytes - 1);
         m_ready     = toggle ? ((cyc % 2) == 0) : 1'b1;
         desc_valid  = hold_next;
         desc_action = next_act;
         #1;
         chk1("stream_sop_low", pkt_sop, 1'b0);
         chk1("stream_desc_ready", desc_ready, 1'b0);
         chk("stream_action_held", action, cur_action);
         if (bi < exp_out) begin
            chk1("stream_m_valid", m_valid, 1'b1);
            chk1("stream_s_ready_tracks", s_ready, m_ready);
            if (m_ready) begin
               chk("stream_m_data", 64'(m_data), 64'(byte_of(p, bi)));
               chk1("stream_m_last", m_last, (bi == exp_out - 1));
               nout++;
            end
         end else begin
            chk1("drain_m_valid", m_valid, 1'b0);
            chk1("drain_s_ready", s_ready, 1'b1);
         end
         if (s_valid && s_ready) bi++;
         cyc++;
         @(posedge clk);
      end
      chk("stream_bytes_accepted", 64'(bi), 64'(stop_after));
      #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
      m_ready = 1'b1;
      if (!hold_next) desc_valid = 1'b0;
   endtask

   task automatic end_check(input int nout, input int exp_out, input int exp_bc);
      @(negedge clk);
      #1;
      chk1("end_busy", busy, 1'b0);
      chk("end_pkt_count", 64'(pkt_count), 64'(exp_pkt));
      chk("end_len_err_count", 64'(len_err_count), 64'(exp_err));
      chk("end_bytes_out", 64'(nout), 64'(exp_out));
      chk("end_byte_counter", 64'(dut.byte_count), 64'(exp_bc));
      chk("end_action_held", action, cur_action);
      chk("end_l2_held", 64'(l2_offset), 64'(cur_l2));
      chk("end_l4_held", 64'(l4_offset), 64'(cur_l4));
   endtask

   initial begin
      int nout;
      checks = 0;
      failures = 0;
      cur_action = 64'd0;
      cur_l2 = 16'd0;
      cur_l3 = 16'd0;
      cur_l4 = 16'd0;
      exp_pkt = 0;
      exp_err = 0;

      vecs[0] = '{16'd4, 4, 64'hB000_0000_0000_0028, 1'b0, 4, 0, 4};
      vecs[1] = '{16'd3, 5, 64'h1111_2222_3333_4444, 1'b0, 3, 1, 3};
      vecs[2] = '{16'd6, 4, 64'h0000_0000_DEAD_BEEF, 1'b0, 4, 1, 4};
      vecs[3] = '{16'd0, 9, 64'h8000_0000_0000_0001, 1'b0, 9, 0, 9};
      vecs[4] = '{16'd5, 5, 64'h0123_4567_89AB_CDEF, 1'b1, 5, 0, 5};
      vecs[5] = '{16'd0, 6, 64'hFEDC_BA98_7654_3210, 1'b1, 6, 0, 6};

      rst = 1'b1;
      desc_valid = 1'b0;
      desc_action = 64'd0;
      desc_len = 16'd0;
      desc_l2_off = 16'd0;
      desc_l3_off = 16'd0;
      desc_l4_off = 16'd0;
      s_valid = 1'b1;
      s_data = 8'h00;
      s_last = 1'b0;
      m_ready = 1'b1;
      #2;
      chk1("rst_desc_ready", desc_ready, 1'b0);
      chk1("rst_s_ready", s_ready, 1'b0);
      chk1("rst_m_valid", m_valid, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_pkt_sop", pkt_sop, 1'b0);
      chk("rst_action", action, 64'd0);
      chk("rst_pkt_count", 64'(pkt_count), 64'd0);
      chk("rst_len_err_count", 64'(len_err_count), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      s_valid = 1'b0;

      for (int i = 0; i < 6; i++) begin
         send_desc(i, vecs[i].act, vecs[i].len, 16'(14 + i), 16'(34 + i), 16'(54 + i));
         stream_pkt(i, vecs[i].nbytes, vecs[i].exp_out, vecs[i].toggle, vecs[i].nbytes,
                    1'b0, 64'd0, nout);
         exp_pkt++;
         exp_err += vecs[i].exp_err;
         end_check(nout, vecs[i].exp_out, vecs[i].exp_bc);
      end

      // Back-to-back: second descriptor held valid while the first packet streams.
      send_desc(10, 64'hAAAA_0000_0000_000A, 16'd3, 16'd1, 16'd2, 16'd3);
      stream_pkt(10, 3, 3, 1'b0, 3, 1'b1, 64'hBBBB_0000_0000_000B, nout);
      chk("b2b_first_bytes_out", 64'(nout), 64'd3);
      send_desc(11, 64'hBBBB_0000_0000_000B, 16'd4, 16'd5, 16'd6, 16'd7);
      stream_pkt(11, 4, 4, 1'b0, 4, 1'b0, 64'd0, nout);
      exp_pkt += 2;
      end_check(nout, 4, 4);

      // Reset after 2 of 8 bytes abandons the packet without counting it.
      send_desc(20, 64'hCCCC_0000_0000_000C, 16'd8, 16'd9, 16'd10, 16'd11);
      stream_pkt(20, 8, 8, 1'b0, 2, 1'b0, 64'd0, nout);
      @(negedge clk);
      s_valid = 1'b1;
      s_data = byte_of(20, 2);
      rst = 1'b1;
      #1;
      chk1("midrst_busy", busy, 1'b0);
      chk1("midrst_desc_ready", desc_ready, 1'b0);
      chk1("midrst_s_ready", s_ready, 1'b0);
      chk1("midrst_m_valid", m_valid, 1'b0);
      chk("midrst_action", action, 64'd0);
      chk("midrst_l2", 64'(l2_offset), 64'd0);
      chk("midrst_pkt_count", 64'(pkt_count), 64'd0);
      chk("midrst_len_err_count", 64'(len_err_count), 64'd0);
      cur_action = 64'd0;
      exp_pkt = 0;
      exp_err = 0;
      @(negedge clk);
      rst = 1'b0;
      s_valid = 1'b0;
      send_desc(21, 64'hDDDD_0000_0000_000D, 16'd4, 16'd12, 16'd13, 16'd14);
      stream_pkt(21, 4, 4, 1'b0, 4, 1'b0, 64'd0, nout);
      exp_pkt = 1;
      end_check(nout, 4, 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
